// File: rtl/a2d_arbiter_pkg.sv
// Shared types and default constants for the A2D arbiter and its watchdog.
package a2d_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_START      = 2'd1,
        ST_WAIT_CMPLT = 2'd2,
        ST_DONE       = 2'd3
    } state_t;

    typedef enum logic {
        OWN_MOT = 1'b0,
        OWN_HK  = 1'b1
    } owner_t;

    localparam logic [11:0] TIMEOUT_CYC_DEF = 12'd4095;
    localparam logic [2:0]  STARVE_LIM_DEF  = 3'd4;

endpackage

// File: rtl/a2d_wdog.sv
// Conversion watchdog: cleared by load, counts while enabled, flags expiry
// once the count equals TIMEOUT_CYC. The count holds at expiry so it never wraps.
module a2d_wdog
    import a2d_arbiter_pkg::*;
#(
    parameter logic [11:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [11:0] cnt;

    assign expired = (cnt == TIMEOUT_CYC);

    // Count cycles spent waiting for conversion complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 12'd0;
        end else if (load) begin
            cnt <= 12'd0;
        end else if (en && !expired) begin
            cnt <= cnt + 12'd1;
        end
    end

endmodule

// File: rtl/a2d_arbiter.sv
// Arbitrates the single A2D converter between the motion controller and the
// housekeeping monitor. Motion has priority unless housekeeping has been
// passed over STARVE_LIM times in a row. Each conversion is guarded by a
// watchdog; a timed-out conversion reports res = 0 and sets a sticky error.
module a2d_arbiter
    import a2d_arbiter_pkg::*;
#(
    parameter logic [11:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [2:0]  STARVE_LIM  = STARVE_LIM_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_mot,
    input  logic [2:0]  chnnl_mot,
    input  logic        req_hk,
    input  logic [2:0]  chnnl_hk,
    output logic        gnt_mot,
    output logic        gnt_hk,
    output logic        done_mot,
    output logic        done_hk,
    output logic [11:0] res,
    output logic        timeout_err,
    output logic        a2d_strt_cnv,
    output logic [2:0]  a2d_chnnl,
    input  logic        a2d_cnv_cmplt,
    input  logic [11:0] a2d_res
);

    state_t      state;
    owner_t      owner;
    logic [2:0]  starve_cnt;
    logic        hk_wins;
    logic        grant;
    logic        wdog_expired;

    // Housekeeping only beats a pending motion request once it has starved.
    assign hk_wins = req_hk && (!req_mot || (starve_cnt == STARVE_LIM));
    assign grant   = (state == ST_IDLE) && (req_mot || req_hk);

    a2d_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .load   (state == ST_START),
        .en     (state == ST_WAIT_CMPLT),
        .expired(wdog_expired)
    );

    // Track how many motion grants housekeeping has waited through.
    always_ff @(posedge clk) begin
        if (rst || !req_hk) begin
            starve_cnt <= 3'd0;
        end else if (grant) begin
            if (hk_wins) begin
                starve_cnt <= 3'd0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 3'd1;
            end
        end
    end

    // Main sequencer: grant, start pulse, wait for completion or timeout, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            owner        <= OWN_MOT;
            gnt_mot      <= 1'b0;
            gnt_hk       <= 1'b0;
            done_mot     <= 1'b0;
            done_hk      <= 1'b0;
            res          <= 12'h000;
            timeout_err  <= 1'b0;
            a2d_strt_cnv <= 1'b0;
            a2d_chnnl    <= 3'd0;
        end else begin
            a2d_strt_cnv <= 1'b0;
            done_mot     <= 1'b0;
            done_hk      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_mot || req_hk) begin
                        owner     <= hk_wins ? OWN_HK : OWN_MOT;
                        a2d_chnnl <= hk_wins ? chnnl_hk : chnnl_mot;
                        gnt_hk    <= hk_wins;
                        gnt_mot   <= !hk_wins;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    a2d_strt_cnv <= 1'b1;
                    state        <= ST_WAIT_CMPLT;
                end
                ST_WAIT_CMPLT: begin
                    // Completion takes precedence over a coincident timeout.
                    if (a2d_cnv_cmplt) begin
                        res      <= a2d_res;
                        done_mot <= (owner == OWN_MOT);
                        done_hk  <= (owner == OWN_HK);
                        state    <= ST_DONE;
                    end else if (wdog_expired) begin
                        res         <= 12'h000;
                        timeout_err <= 1'b1;
                        done_mot    <= (owner == OWN_MOT);
                        done_hk     <= (owner == OWN_HK);
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    gnt_mot <= 1'b0;
                    gnt_hk  <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/a2d_arbiter.md
A2D_ARBITER -- requirements
Module: a2d_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 12'd4095: cycles to wait for a2d_cnv_cmplt after a2d_strt_cnv before aborting.
REQ-002 Parameter STARVE_LIM, default 3'd4: consecutive motion grants allowed while housekeeping waits.
REQ-003 The block SHALL use one clock, clk; reset is rst, synchronous and active-high.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_mot  in  1  motion-controller conversion request, level, held until done_mot.
REQ-007 chnnl_mot  in  3  motion channel, stable while req_mot high.
REQ-008 req_hk  in  1  housekeeping (battery monitor) request, level, held until done_hk.
REQ-009 chnnl_hk  in  3  housekeeping channel, stable while req_hk high.
REQ-010 gnt_mot / gnt_hk  out  1 each  owner indication, START through DONE.
REQ-011 done_mot / done_hk  out  1 each  one-cycle result-valid pulse.
REQ-012 res  out  12  last conversion result.
REQ-013 timeout_err  out  1  sticky: some conversion timed out.
REQ-014 a2d_strt_cnv  out  1  start pulse to the A2D interface.
REQ-015 a2d_chnnl  out  3  channel to the A2D interface, held from START through DONE.
REQ-016 a2d_cnv_cmplt  in  1  conversion-complete from the A2D interface.
REQ-017 a2d_res  in  12  conversion result from the A2D interface.

Function
REQ-018 The FSM SHALL have states IDLE, START, WAIT_CMPLT and DONE, with all outputs registered or Moore-decoded.
REQ-019 In IDLE with any request pending, the FSM SHALL latch the winner and its channel and go to START next cycle.
REQ-020 Arbitration SHALL be fixed-priority motion over housekeeping, except housekeeping wins when starve_cnt == STARVE_LIM.
REQ-021 starve_cnt SHALL increment on each motion grant while req_hk is high, saturate at STARVE_LIM, and clear on a housekeeping grant or whenever req_hk is low.
REQ-022 START SHALL assert a2d_strt_cnv for exactly one cycle, load the timeout counter with 0, and go to WAIT_CMPLT.
REQ-023 WAIT_CMPLT SHALL increment the timeout counter each cycle; on a2d_cnv_cmplt it SHALL capture a2d_res into res and go to DONE.
REQ-024 If the counter reaches TIMEOUT_CYC without a2d_cnv_cmplt, the FSM SHALL set res to 12'h000, set timeout_err, and go to DONE.
REQ-025 If a2d_cnv_cmplt and timeout occur in the same cycle, completion SHALL win and timeout_err SHALL be unchanged.
REQ-026 DONE SHALL pulse done_x of the owner for one cycle, then return to IDLE; gnt_x drops on entry to IDLE.
REQ-027 A requester SHALL drop req the cycle after done_x; req still high in IDLE is treated as a new request.
REQ-028 a2d_cnv_cmplt in IDLE, START or DONE SHALL be ignored.
REQ-029 Channel or request changes by the owner after the grant SHALL not affect a2d_chnnl.
REQ-030 Latency SHALL be 2 cycles from req in IDLE to a2d_strt_cnv, and 1 cycle from a2d_cnv_cmplt to done_x.

Reset
REQ-031 On rst the FSM SHALL go to IDLE and all of the following SHALL clear to 0: gnt_*, done_*, a2d_strt_cnv, a2d_chnnl, res, timeout_err, starve_cnt and the timeout counter.
REQ-032 A reset mid-conversion SHALL abandon it without a done pulse, and the late a2d_cnv_cmplt SHALL be ignored.

Structure
REQ-033 A shared package SHALL hold the state enum, the requester-ID enum (OWN_MOT, OWN_HK) and the default TIMEOUT_CYC/STARVE_LIM constants.
REQ-034 The timeout counter SHALL be one sub-module, a2d_wdog (load, enable, expired flag); everything else stays inline.

Verification
REQ-035 Single motion request: req_mot=1, chnnl_mot=3'b100, cnv_cmplt 10 cycles after strt_cnv with a2d_res=12'hA5C -> a2d_chnnl=3'b100, strt_cnv 1 cycle, done_mot 1 cycle, res=12'hA5C.
REQ-036 Simultaneous requests in IDLE -> motion granted first, then housekeeping, with no overlap of gnt_mot/gnt_hk.
REQ-037 Starvation: req_mot re-asserted continuously, req_hk held -> after 4 motion grants the 5th grant goes to housekeeping, then starve_cnt=0.
REQ-038 Timeout: no cnv_cmplt, TIMEOUT_CYC=12'd20 -> done pulse 21 cycles after strt_cnv, res=0, timeout_err=1, staying 1 through later normal conversions.
REQ-039 Boundary: cnv_cmplt on the expiry cycle -> res captured, timeout_err stays 0.
REQ-040 Reset in WAIT_CMPLT, cnv_cmplt 2 cycles later -> no done pulse, all outputs 0, FSM in IDLE.
